// File: rtl/clock_pkg.sv
// Shared types and constants for the digital clock: controller state encoding
// and the hour/minute field widths and ranges used by the time counters.
package clock_pkg;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    SET_HR  = 2'd1,
    SET_MIN = 2'd2,
    COMMIT  = 2'd3
  } state_t;

  localparam int HR_W        = 5;
  localparam int MIN_W       = 6;
  localparam int HR_MAX_DEF  = 23;
  localparam int MIN_MAX_DEF = 59;
  localparam int TMO_W       = 6;

endpackage

// File: rtl/wrap_updown.sv
// Wrapping up/down register over 0..MAX with a parallel load, used for the
// hour and minute fields being edited.
module wrap_updown #(
  parameter int W   = 5,
  parameter int MAX = 23
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         inc,
  input  logic         dec,
  input  logic         en,
  output logic [W-1:0] value
);

  // inc and dec together cancel; load beats any step request.
  always_ff @(posedge clk) begin
    if (rst) begin
      value <= '0;
    end else if (load) begin
      value <= load_val;
    end else if (en && inc && !dec) begin
      value <= (value == W'(MAX)) ? '0 : value + 1'b1;
    end else if (en && dec && !inc) begin
      value <= (value == '0) ? W'(MAX) : value - 1'b1;
    end
  end

endmodule

// File: rtl/clock_set_ctrl.sv
// Time-set controller: edits hours then minutes from three button levels,
// holds the time counters while editing and issues a one-cycle load on confirm.
module clock_set_ctrl
  import clock_pkg::*;
#(
  parameter int HR_MAX    = HR_MAX_DEF,
  parameter int MIN_MAX   = MIN_MAX_DEF,
  parameter int TIMEOUT_S = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              tick_1hz,
  input  logic              btn_mode,
  input  logic              btn_inc,
  input  logic              btn_dec,
  input  logic [HR_W-1:0]   cur_hr,
  input  logic [MIN_W-1:0]  cur_min,
  output logic              run_en,
  output logic              load_en,
  output logic [HR_W-1:0]   load_hr,
  output logic [MIN_W-1:0]  load_min,
  output logic              edit_hr,
  output logic              edit_min,
  output logic              blink,
  output logic [1:0]        state_dbg
);

  state_t state, state_next;

  logic mode_q, inc_q, dec_q;
  logic mode_ev, inc_ev, dec_ev, any_ev;
  logic editing, timeout;
  logic [TMO_W-1:0] tmo_cnt;

  // Buttons are level inputs; an event is the first cycle a level is seen high,
  // so holding a button yields exactly one event.
  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q <= 1'b0;
      inc_q  <= 1'b0;
      dec_q  <= 1'b0;
    end else begin
      mode_q <= btn_mode;
      inc_q  <= btn_inc;
      dec_q  <= btn_dec;
    end
  end

  assign mode_ev = btn_mode & ~mode_q;
  assign inc_ev  = btn_inc & ~inc_q;
  assign dec_ev  = btn_dec & ~dec_q;
  assign any_ev  = mode_ev | inc_ev | dec_ev;

  assign editing = (state == SET_HR) || (state == SET_MIN);
  // Any press in the expiring cycle keeps the edit alive.
  assign timeout = editing && tick_1hz && !any_ev &&
                   (tmo_cnt == TMO_W'(TIMEOUT_S - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RUN;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      RUN:     if (mode_ev) state_next = SET_HR;
      SET_HR:  if (mode_ev) state_next = SET_MIN;
               else if (timeout) state_next = RUN;
      SET_MIN: if (mode_ev) state_next = COMMIT;
               else if (timeout) state_next = RUN;
      COMMIT:  state_next = RUN;
      default: state_next = RUN;
    endcase
  end

  always_comb begin
    run_en   = 1'b0;
    load_en  = 1'b0;
    edit_hr  = 1'b0;
    edit_min = 1'b0;
    case (state)
      RUN:     run_en   = 1'b1;
      SET_HR:  edit_hr  = 1'b1;
      SET_MIN: edit_min = 1'b1;
      COMMIT:  load_en  = 1'b1;
      default: run_en   = 1'b1;
    endcase
  end

  assign state_dbg = state;

  always_ff @(posedge clk) begin
    if (rst || !editing || any_ev) begin
      tmo_cnt <= '0;
    end else if (tick_1hz) begin
      tmo_cnt <= tmo_cnt + 1'b1;
    end
  end

  // Blink is forced on whenever the edited value changes so it is seen at once.
  always_ff @(posedge clk) begin
    if (rst) begin
      blink <= 1'b0;
    end else if (state_next == RUN || state_next == COMMIT) begin
      blink <= 1'b0;
    end else if (state == RUN) begin
      blink <= 1'b1;
    end else if ((inc_ev || dec_ev) && !mode_ev) begin
      blink <= 1'b1;
    end else if (tick_1hz) begin
      blink <= ~blink;
    end
  end

  wrap_updown #(.W(HR_W), .MAX(HR_MAX)) u_hr (
    .clk      (clk),
    .rst      (rst),
    .load     ((state == RUN) && mode_ev),
    .load_val (cur_hr),
    .inc      (inc_ev),
    .dec      (dec_ev),
    .en       ((state == SET_HR) && !mode_ev),
    .value    (load_hr)
  );

  wrap_updown #(.W(MIN_W), .MAX(MIN_MAX)) u_min (
    .clk      (clk),
    .rst      (rst),
    .load     ((state == RUN) && mode_ev),
    .load_val (cur_min),
    .inc      (inc_ev),
    .dec      (dec_ev),
    .en       ((state == SET_MIN) && !mode_ev),
    .value    (load_min)
  );

endmodule

// File: doc/clock_set_ctrl.md
Name: clock_set_ctrl

Overview:
Time-set controller for the digital clock. It sequences the user through editing hours, then minutes, from three debounced push-button levels. While editing it holds the free-running time counters and drives a display blink. On confirm it issues a one-cycle parallel load of the edited values into the hour/minute counters; on inactivity timeout it abandons the edit.

Parameters:
HR_MAX, 23, highest hour value (23 = 24 h mode; 12 h mode is out of scope)
MIN_MAX, 59, highest minute value
TIMEOUT_S, 10, whole seconds of no button activity before an edit is abandoned (range 2..63)

Ports:
clk  in  1  system clock
rst  in  1  reset
tick_1hz  in  1  one-cycle pulse per second from the seconds stage
btn_mode  in  1  debounced, synchronized level: mode/confirm button
btn_inc  in  1  debounced, synchronized level: increment button
btn_dec  in  1  debounced, synchronized level: decrement button
cur_hr  in  5  live hour count
cur_min  in  6  live minute count
run_en  out  1  1 = time counters may advance; 0 = hold
load_en  out  1  one-cycle strobe: counters take load_hr/load_min
load_hr  out  5  hour value to load / value shown while editing
load_min  out  6  minute value to load / value shown while editing
edit_hr  out  1  hour field being edited (display blink target)
edit_min  out  1  minute field being edited
blink  out  1  blink phase for the edited field

Behaviour:
- Reset is rst, synchronous, active-high, on clock clk. Reset values:
  - state=RUN, run_en=1, load_en=0, load_hr=0, load_min=0, edit_hr=0, edit_min=0, blink=0
  - button history registers=0, timeout counter=0
- Button edge detect:
  - Each btn_* is registered once. A press event is (btn & ~btn_q).
  - Events are acted on in the cycle after the rising level, so latency is 1 clk.
  - Holding a button produces exactly one event; there is no auto-repeat.
- FSM states: RUN, SET_HR, SET_MIN, COMMIT. The state encoding lives in the package.
- RUN:
  - run_en=1; edit_* = 0; blink=0.
  - mode event: copy cur_hr into load_hr and cur_min into load_min, clear the timeout counter, go to SET_HR.
  - inc/dec events are ignored.
- SET_HR:
  - run_en=0; edit_hr=1.
  - inc: load_hr = (load_hr==HR_MAX) ? 0 : load_hr+1.
  - dec: load_hr = (load_hr==0) ? HR_MAX : load_hr-1.
  - mode event goes to SET_MIN.
- SET_MIN:
  - Same rules as SET_HR, applied to load_min with MIN_MAX; edit_min=1.
  - mode event goes to COMMIT.
- COMMIT:
  - Lasts exactly 1 cycle: load_en=1, run_en=0, then RUN.
  - load_hr/load_min are stable during the strobe.
  - run_en returns to 1 on the following cycle.
- Simultaneous events in a set state:
  - mode together with inc and/or dec: mode wins; inc/dec are discarded.
  - inc together with dec, no mode: no change, but the timeout counter is still cleared.
- Timeout:
  - In SET_HR/SET_MIN, the counter increments on each tick_1hz and is cleared on any press event.
  - When the counter would reach TIMEOUT_S, go to RUN with no load_en. Counters resume from their held values.
  - A press event in the same cycle as the expiring tick takes priority, and the timeout does not occur.
- Blink:
  - Forced to 1 on entry to SET_HR and on any inc/dec event, so the edited value is visible immediately.
  - Otherwise toggles on each tick_1hz while in a set state.
  - 0 in RUN and COMMIT.
- Reset mid-edit: returns to RUN immediately; no load_en is issued.
- Width rules: arithmetic is at native field width. Values never leave the 0..MAX range. cur_* inputs are sampled only on RUN→SET_HR.

Decomposition:
- Package clock_pkg:
  - state enum (RUN, SET_HR, SET_MIN, COMMIT)
  - HR_W=5, MIN_W=6
  - default HR_MAX/MIN_MAX constants, shared with the counter modules
- One natural sub-module, wrap_updown: parameterized width/max, inputs inc/dec/en, wrapping register. It is instantiated twice, for hours and minutes.
- Edge detect and timeout stay inline.

Test Plan:
- Reset, then cur_hr=13, cur_min=45, press mode → after 1 clk: state SET_HR, run_en=0, load_hr=13, load_min=45, edit_hr=1, blink=1.
- In SET_HR, load_hr=23, press inc once → load_hr=0; press dec → load_hr=23; hold inc for 100 clk → exactly one increment.
- Full set sequence: mode, inc×2 (13→15), mode, dec×46 (45→59 via wrap at 0), mode → exactly one cycle with load_en=1, load_hr=15, load_min=59; next cycle run_en=1 and state RUN.
- Enter SET_MIN, apply no presses, drive 10 tick_1hz pulses → return to RUN with load_en never asserted; run_en=1. Repeat with a press coinciding with the 10th tick → stays in SET_MIN.
- In SET_MIN, mode+inc rising in the same cycle → COMMIT with load_min unchanged. Separately, inc+dec together → value unchanged and the timeout counter cleared.
- Assert rst while in SET_HR with load_hr edited → next cycle all outputs at reset values; no load_en pulse at any point.
